// File: rtl/corevx_ptw_pkg.sv
// Shared definitions for the corevx Sv32 page-table walker: state encoding,
// PTE bit positions, bus response codes and the PTE address helper.
package corevx_ptw_pkg;

    localparam int VPN_W = 20;
    localparam int PPN_W = 22;
    localparam int PA_W  = 34;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } ptw_state_t;

    // PTE flag positions; the accesstag is PTE[PTE_D:PTE_V] unchanged.
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_D = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [PA_W-1:0] pte_address(input logic [PPN_W-1:0] table_ppn,
                                                    input logic [VPN_W-1:0] vpn,
                                                    input logic             level);
        return {table_ppn, (level ? vpn[19:10] : vpn[9:0]), 2'b00};
    endfunction

endpackage

// File: rtl/corevx_ptw.sv
// Sv32 page-table walker: fetches up to two PTEs over Avalon-MM and returns
// the leaf PPN with its accesstag, a pagefault or an accessfault.
module corevx_ptw
    import corevx_ptw_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                resolve_request,
    input  logic [VPN_W-1:0]    resolve_virtual_address,
    input  logic [PPN_W-1:0]    satp_ppn,
    output logic                resolve_done,
    output logic                resolve_pagefault,
    output logic                resolve_accessfault,
    output logic [PPN_W-1:0]    resolve_physical_address,
    output logic [7:0]          resolve_access_bits,
    output logic [PA_W-1:0]     avl_address,
    output logic                avl_read,
    input  logic                avl_waitrequest,
    input  logic                avl_readdatavalid,
    input  logic [31:0]         avl_readdata,
    input  logic [1:0]          avl_response
);

    ptw_state_t         state;
    logic               level;
    logic [PPN_W-1:0]   table_ppn;
    logic [VPN_W-1:0]   vpn;

    logic [31:0]        pte;
    logic               pte_invalid;
    logic               pte_leaf;
    logic               megapage_misaligned;
    logic               unused_rsw;

    assign pte                 = avl_readdata;
    assign pte_invalid         = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
    assign pte_leaf            = pte[PTE_R] | pte[PTE_X];
    assign megapage_misaligned = level && (pte[19:10] != 10'd0);
    // The software-reserved RSW bits carry no meaning for the walk.
    assign unused_rsw          = ^pte[9:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= ST_IDLE;
            level                    <= 1'b0;
            table_ppn                <= '0;
            vpn                      <= '0;
            resolve_done             <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= '0;
            resolve_access_bits      <= '0;
            avl_address              <= '0;
            avl_read                 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (resolve_request) begin
                        vpn         <= resolve_virtual_address;
                        table_ppn   <= satp_ppn;
                        level       <= 1'b1;
                        avl_read    <= 1'b1;
                        avl_address <= pte_address(satp_ppn, resolve_virtual_address, 1'b1);
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!avl_waitrequest) begin
                        avl_read <= 1'b0;
                        state    <= ST_WAIT_DATA;
                    end
                end

                ST_WAIT_DATA: begin
                    if (avl_readdatavalid) begin
                        if (avl_response != RESP_OKAY) begin
                            resolve_accessfault      <= 1'b1;
                            resolve_physical_address <= '0;
                            resolve_access_bits      <= '0;
                            resolve_done             <= 1'b1;
                            state                    <= ST_DONE;
                        end else if (pte_invalid || (pte_leaf && megapage_misaligned) ||
                                     (!pte_leaf && !level)) begin
                            resolve_pagefault        <= 1'b1;
                            resolve_physical_address <= '0;
                            resolve_access_bits      <= '0;
                            resolve_done             <= 1'b1;
                            state                    <= ST_DONE;
                        end else if (pte_leaf) begin
                            // Megapage leaves take the low VPN straight through as PPN[9:0].
                            resolve_physical_address <= level ? {pte[31:20], vpn[9:0]} : pte[31:10];
                            resolve_access_bits      <= pte[PTE_D:PTE_V];
                            resolve_done             <= 1'b1;
                            state                    <= ST_DONE;
                        end else begin
                            level       <= 1'b0;
                            table_ppn   <= pte[31:10];
                            avl_read    <= 1'b1;
                            avl_address <= pte_address(pte[31:10], vpn, 1'b0);
                            state       <= ST_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    resolve_done             <= 1'b0;
                    resolve_pagefault        <= 1'b0;
                    resolve_accessfault      <= 1'b0;
                    resolve_physical_address <= '0;
                    resolve_access_bits      <= '0;
                    state                    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corevx_ptw.sv
// Self-checking bench for corevx_ptw: directed vector table, stall/reset
// sequences and randomized walks against a page-table memory model.
module tb_corevx_ptw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] satp_ppn;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_waitrequest;
    logic        avl_readdatavalid;
    logic [31:0] avl_readdata;
    logic [1:0]  avl_response;

    corevx_ptw dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .satp_ppn                 (satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .avl_address              (avl_address),
        .avl_read                 (avl_read),
        .avl_waitrequest          (avl_waitrequest),
        .avl_readdatavalid        (avl_readdatavalid),
        .avl_readdata             (avl_readdata),
        .avl_response             (avl_response)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Page-table memory and per-address bus response, written by the test.
    logic [31:0] mem      [logic [33:0]];
    logic [1:0]  resp_mem [logic [33:0]];

    int lat_cfg    = 0;
    int stall_cfg  = 0;
    bit rand_stall = 1'b0;

    // Bus slave state, owned by the responder process only.
    bit          pending   = 1'b0;
    int          lat_cnt   = 0;
    int          stall_cnt = 0;
    logic [33:0] pend_addr = '0;

    // Walk observations, owned by the main process.
    int          walk_reads;
    logic [33:0] walk_addrs[$];

    typedef struct {
        logic [21:0] satp;
        logic [19:0] vpn;
        logic [31:0] pte1;
        logic [1:0]  resp1;
        logic [31:0] pte0;
        logic [1:0]  resp0;
        int          lat;
        logic [33:0] addr1;
        logic [33:0] addr0;
        int          nrd;
        logic        pf;
        logic        af;
        logic [21:0] ppn;
        logic [7:0]  bits;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Avalon slave: decides waitrequest for the next edge and returns read data
    // a configurable number of cycles after each accepted read.
    always @(negedge clk) begin
        avl_readdatavalid = 1'b0;
        avl_readdata      = $urandom();
        avl_response      = 2'b00;
        if (!rst_n) begin
            pending   = 1'b0;
            stall_cnt = 0;
            avl_waitrequest = 1'b0;
        end else begin
            if (pending) begin
                if (lat_cnt == 0) begin
                    avl_readdatavalid = 1'b1;
                    avl_readdata      = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                    avl_response      = resp_mem.exists(pend_addr) ? resp_mem[pend_addr] : 2'b00;
                    pending           = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (!avl_read) begin
                stall_cnt       = 0;
                avl_waitrequest = rand_stall ? ($urandom_range(0, 1) == 0) : 1'b0;
            end else if (stall_cnt < stall_cfg) begin
                stall_cnt++;
                avl_waitrequest = 1'b1;
            end else begin
                avl_waitrequest = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (avl_read && !avl_waitrequest) begin
                pending   = 1'b1;
                lat_cnt   = lat_cfg;
                pend_addr = avl_address;
            end
        end
    end

    // Reference walk computed from the Sv32 rules over the memory contents.
    function automatic void modelWalk(input logic [21:0] satp, input logic [19:0] vpn,
                                      output logic pf, output logic af,
                                      output logic [21:0] ppn, output logic [7:0] bits,
                                      output int nreads);
        longint      base;
        longint      addr;
        longint      p;
        logic [33:0] key;
        logic [31:0] pte;
        pf = 0; af = 0; ppn = 0; bits = 0; nreads = 0;
        base = longint'(satp);
        for (int lvl = 1; lvl >= 0; lvl--) begin
            addr = base * 4096 + ((lvl == 1) ? longint'(vpn) / 1024 : longint'(vpn) % 1024) * 4;
            key  = addr[33:0];
            nreads++;
            if (resp_mem.exists(key) && resp_mem[key] != 2'b00) begin
                af = 1; return;
            end
            pte = mem.exists(key) ? mem[key] : 32'h0;
            p   = longint'(pte);
            if (!pte[0] || (pte[2] && !pte[1])) begin
                pf = 1; return;
            end
            if (pte[1] || pte[3]) begin
                if (lvl == 1 && (p / 1024) % 1024 != 0) begin
                    pf = 1; return;
                end
                ppn  = (lvl == 1) ? 22'((p / 1048576) * 1024 + longint'(vpn) % 1024) : 22'(p / 1024);
                bits = 8'(p % 256);
                return;
            end
            if (lvl == 0) begin
                pf = 1; return;
            end
            base = p / 1024;
        end
    endfunction

    // One walk: request for one cycle, then scramble the inputs while busy.
    task automatic runWalk(input logic [21:0] satp, input logic [19:0] vpn,
                           output int cycles, output logic pf, output logic af,
                           output logic [21:0] ppn, output logic [7:0] bits);
        logic        held;
        logic [33:0] held_addr;
        held       = 1'b0;
        held_addr  = '0;
        walk_reads = 0;
        walk_addrs.delete();
        @(negedge clk);
        #1;
        resolve_request         = 1'b1;
        satp_ppn                = satp;
        resolve_virtual_address = vpn;
        cycles = 0;
        do begin
            @(negedge clk);
            #1;
            cycles++;
            resolve_request         = 1'b0;
            satp_ppn                = 22'($urandom());
            resolve_virtual_address = 20'($urandom());
            if (held) checkOutput("addr_held_in_stall", {29'd0, avl_read, avl_address}, {29'd0, 1'b1, held_addr});
            held      = avl_read && avl_waitrequest;
            held_addr = avl_address;
            if (avl_read && !avl_waitrequest) begin
                walk_reads++;
                walk_addrs.push_back(avl_address);
            end
        end while (!resolve_done && cycles < 200);
        checkOutput("done_seen", {63'd0, resolve_done}, 64'd1);
        checkOutput("faults_exclusive", {63'd0, resolve_pagefault & resolve_accessfault}, 64'd0);
        pf   = resolve_pagefault;
        af   = resolve_accessfault;
        ppn  = resolve_physical_address;
        bits = resolve_access_bits;
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", {63'd0, resolve_done}, 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        longint      l1;
        longint      l0;
        int          cycles;
        logic        pf;
        logic        af;
        logic [21:0] ppn;
        logic [7:0]  bits;
        string       tag;
        mem.delete();
        resp_mem.delete();
        l1 = longint'(v.satp) * 4096 + (longint'(v.vpn) / 1024) * 4;
        l0 = (longint'(v.pte1) / 1024) * 4096 + (longint'(v.vpn) % 1024) * 4;
        mem[l0[33:0]]      = v.pte0;
        resp_mem[l0[33:0]] = v.resp0;
        mem[l1[33:0]]      = v.pte1;
        resp_mem[l1[33:0]] = v.resp1;
        lat_cfg = v.lat;
        runWalk(v.satp, v.vpn, cycles, pf, af, ppn, bits);
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, "_cycles"}, 64'(cycles), 64'(v.cyc));
        checkOutput({tag, "_reads"}, 64'(walk_reads), 64'(v.nrd));
        checkOutput({tag, "_faults"}, {62'd0, pf, af}, {62'd0, v.pf, v.af});
        checkOutput({tag, "_ppn"}, 64'(ppn), 64'(v.ppn));
        checkOutput({tag, "_bits"}, 64'(bits), 64'(v.bits));
        if (walk_reads > 0) checkOutput({tag, "_addr1"}, 64'(walk_addrs[0]), 64'(v.addr1));
        if (walk_reads > 1) checkOutput({tag, "_addr0"}, 64'(walk_addrs[1]), 64'(v.addr0));
    endtask

    function automatic logic [31:0] randPte(input int kind);
        logic [31:0] r;
        r = $urandom();
        case (kind)
            0:       return (r & 32'hFFFFFC00) | 32'h1;
            1:       return (r & 32'hFFF000FF) | 32'h3;
            2:       return r | 32'h1;
            default: return r;
        endcase
    endfunction

    initial begin
        vec_t        v;
        int          cycles;
        int          nreads;
        int          done_seen;
        logic        pf, af, epf, eaf;
        logic [21:0] ppn, eppn;
        logic [7:0]  bits, ebits;
        longint      l1, l0;
        logic [21:0] satp;
        logic [19:0] vpn;

        rst_n                   = 1'b0;
        resolve_request         = 1'b0;
        resolve_virtual_address = '0;
        satp_ppn                = '0;
        avl_waitrequest         = 1'b0;
        avl_readdatavalid       = 1'b0;
        avl_readdata            = '0;
        avl_response            = 2'b00;

        #1;
        checkOutput("reset_result", {30'd0, resolve_done, resolve_pagefault, resolve_accessfault,
                                     resolve_physical_address, resolve_access_bits}, 64'd0);
        checkOutput("reset_bus", {29'd0, avl_read, avl_address}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //              satp      vpn       pte1          r1     pte0          r0     lat addr1          addr0         nrd pf af ppn       bits  cyc
        vecs[0] = '{22'h00100, 20'h12345, 32'h00080001, 2'b00, 32'h012345CF, 2'b00, 0, 34'h000100120, 34'h000200D14, 2, 0, 0, 22'h048D1, 8'hCF, 5};
        vecs[1] = '{22'h00100, 20'h12345, 32'h2000000F, 2'b00, 32'h00000000, 2'b00, 0, 34'h000100120, 34'h0,         1, 0, 0, 22'h80345, 8'h0F, 3};
        vecs[2] = '{22'h00100, 20'h12345, 32'h00000C0F, 2'b00, 32'h00000000, 2'b00, 0, 34'h000100120, 34'h0,         1, 1, 0, 22'h0,     8'h00, 3};
        vecs[3] = '{22'h00100, 20'h12345, 32'h00000000, 2'b00, 32'h00000000, 2'b00, 0, 34'h000100120, 34'h0,         1, 1, 0, 22'h0,     8'h00, 3};
        vecs[4] = '{22'h00100, 20'h12345, 32'h00000005, 2'b00, 32'h00000000, 2'b00, 0, 34'h000100120, 34'h0,         1, 1, 0, 22'h0,     8'h00, 3};
        vecs[5] = '{22'h00100, 20'h12345, 32'h00080001, 2'b00, 32'h00080001, 2'b00, 0, 34'h000100120, 34'h000200D14, 2, 1, 0, 22'h0,     8'h00, 5};
        vecs[6] = '{22'h00100, 20'h12345, 32'h00080001, 2'b00, 32'h012345CF, 2'b10, 0, 34'h000100120, 34'h000200D14, 2, 0, 1, 22'h0,     8'h00, 5};
        vecs[7] = '{22'h00100, 20'h12345, 32'h00080001, 2'b00, 32'h012345CF, 2'b00, 2, 34'h000100120, 34'h000200D14, 2, 0, 0, 22'h048D1, 8'hCF, 9};
        vecs[8] = '{22'h00100, 20'h12345, 32'h00080001, 2'b00, 32'h01234509, 2'b00, 0, 34'h000100120, 34'h000200D14, 2, 0, 0, 22'h048D1, 8'h09, 5};
        vecs[9] = '{22'h00100, 20'h12345, 32'h2000000F, 2'b11, 32'h00000000, 2'b00, 0, 34'h000100120, 34'h0,         1, 0, 1, 22'h0,     8'h00, 3};

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        // Three stalled cycles on a megapage read: address held, done three cycles late.
        v = vecs[1];
        v.cyc = 6;
        stall_cfg = 3;
        applyStimulus(v, 100);
        stall_cfg = 0;

        // Reset while the L1 read is outstanding, then a clean walk afterwards.
        mem.delete();
        resp_mem.delete();
        mem[34'h000100120] = 32'h2000000F;
        lat_cfg = 4;
        @(negedge clk);
        #1;
        resolve_request         = 1'b1;
        satp_ppn                = 22'h00100;
        resolve_virtual_address = 20'h12345;
        @(negedge clk);
        #1;
        resolve_request = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midwalk_reset_result", {30'd0, resolve_done, resolve_pagefault, resolve_accessfault,
                                             resolve_physical_address, resolve_access_bits}, 64'd0);
        checkOutput("midwalk_reset_bus", {29'd0, avl_read, avl_address}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (resolve_done) done_seen++;
        end
        checkOutput("no_done_after_reset", 64'(done_seen), 64'd0);
        applyStimulus(vecs[0], 200);

        // Randomized walks against the reference model.
        for (int it = 0; it < 60; it++) begin
            mem.delete();
            resp_mem.delete();
            satp       = 22'($urandom());
            vpn        = 20'($urandom());
            lat_cfg    = $urandom_range(0, 2);
            rand_stall = ($urandom_range(0, 1) == 1);
            v.pte1 = randPte((it % 3 == 0) ? 3 : $urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0) v.pte1 = randPte(0);
            v.pte0 = randPte($urandom_range(0, 3));
            l1 = longint'(satp) * 4096 + (longint'(vpn) / 1024) * 4;
            l0 = (longint'(v.pte1) / 1024) * 4096 + (longint'(vpn) % 1024) * 4;
            mem[l0[33:0]] = v.pte0;
            mem[l1[33:0]] = v.pte1;
            if ($urandom_range(0, 7) == 0) resp_mem[l0[33:0]] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) resp_mem[l1[33:0]] = 2'($urandom_range(1, 3));
            modelWalk(satp, vpn, epf, eaf, eppn, ebits, nreads);
            runWalk(satp, vpn, cycles, pf, af, ppn, bits);
            checkOutput("rand_faults", {62'd0, pf, af}, {62'd0, epf, eaf});
            checkOutput("rand_ppn", 64'(ppn), 64'(eppn));
            checkOutput("rand_bits", 64'(bits), 64'(ebits));
            checkOutput("rand_reads", 64'(walk_reads), 64'(nreads));
            if (!rand_stall) checkOutput("rand_cycles", 64'(cycles), 64'(1 + nreads * (2 + lat_cfg)));
        end
        rand_stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
